dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the single-port data memory in the pipelined CPU. It accepts word requests from two masters: port 0, the MEM stage, and port 1, the loader/debug master. It grants one request at a time under round-robin, then drives the memory read/write strobes for a fixed, parameterised number of wait cycles. It returns read data with a one-cycle completion pulse, and requesters stall on the valid/ready handshake.

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory.
// One transaction in flight at a time; memory command held MEM_LAT cycles per access.
module dmem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req0_write_i,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_wdata_i,
  output logic        req0_ready_o,
  output logic        req0_done_o,
  output logic        req0_err_o,
  input  logic        req1_valid_i,
  input  logic        req1_write_i,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_wdata_i,
  output logic        req1_ready_o,
  output logic        req1_done_o,
  output logic        req1_err_o,
  output logic [31:0] rdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit WR_ON_ACCEPT = (MEM_LAT == 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_port;
  logic            r_write;
  logic            r_last_grant;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_done0;
  logic            r_done1;
  logic            r_err0;
  logic            r_err1;
  logic            r_busy;

  logic            w_idle;
  logic            w_sel;
  logic            w_accept;
  logic            w_sel_write;
  logic [31:0]     w_sel_addr;
  logic [31:0]     w_sel_wdata;
  logic            w_misalign;

  // On a tie, grant the port that did not win last time.
  assign w_idle      = (r_state == S_IDLE);
  assign w_sel       = (req0_valid_i & req1_valid_i) ? ~r_last_grant : req1_valid_i;
  assign w_accept    = w_idle & (req0_valid_i | req1_valid_i);
  assign w_sel_write = w_sel ? req1_write_i : req0_write_i;
  assign w_sel_addr  = w_sel ? req1_addr_i  : req0_addr_i;
  assign w_sel_wdata = w_sel ? req1_wdata_i : req0_wdata_i;
  assign w_misalign  = |w_sel_addr[1:0];

  assign req0_ready_o = w_idle & req0_valid_i & ~w_sel;
  assign req1_ready_o = w_idle & req1_valid_i &  w_sel;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_port       <= 1'b0;
      r_write      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_port       <= w_sel;
            r_write      <= w_sel_write;
            r_addr       <= {w_sel_addr[31:2], 2'b00};
            r_wdata      <= w_sel_wdata;
            r_last_grant <= w_sel;
            r_busy       <= 1'b1;
            r_cnt        <= CW'(MEM_LAT - 1);
            if (w_misalign) begin
              // Misaligned requests complete immediately with an error, no memory strobes.
              r_done0 <= ~w_sel;
              r_done1 <=  w_sel;
              r_err0  <= ~w_sel;
              r_err1  <=  w_sel;
              r_state <= S_DONE;
            end else begin
              r_mem_read  <= ~w_sel_write;
              r_mem_write <= w_sel_write & WR_ON_ACCEPT;
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (r_cnt == '0) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (!r_write) begin
              r_rdata <= mem_rdata_i;
            end
            r_done0 <= ~r_port;
            r_done1 <=  r_port;
            r_state <= S_DONE;
          end else begin
            // Store strobe only in the last ACCESS cycle so memory is written once.
            r_cnt       <= r_cnt - CW'(1);
            r_mem_write <= r_write & (r_cnt == CW'(1));
          end
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_err0  <= 1'b0;
          r_err1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req0_done_o = r_done0;
  assign req1_done_o = r_done1;
  assign req0_err_o  = r_err0;
  assign req1_err_o  = r_err1;
  assign rdata_o     = r_rdata;
  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0, w0, v1, w1;
  logic [31:0] a0, d0, a1, d1;
  logic        rdy0, rdy1, dn0, dn1, er0, er1;
  logic [31:0] rdata, maddr, mwdata, mrdata;
  logic        mrd, mwr, busy;

  logic        b_v0;
  logic [31:0] b_a0;
  logic        b_rdy0, b_rdy1, b_dn0, b_dn1, b_er0, b_er1, b_mrd, b_mwr, b_busy;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;

  logic [31:0] mem [0:63];
  bit          mem_init = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
    int          done_cyc;
    int          nrd;
    int          nwr;
    logic [31:0] waddr;
  } exp_t;

  exp_t sb_q[$];
  int   exp_grant_q[$];
  int   acc_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mrdata   = mem[maddr[7:2]];
  assign b_mrdata = mem[b_maddr[7:2]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[4]   <= 32'hDEAD_BEEF;
      mem_init <= 1'b1;
    end else if (mwr) begin
      mem[maddr[7:2]] <= mwdata;
    end
  end

  dmem_arbiter #(.MEM_LAT(LAT)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(v0), .req0_write_i(w0), .req0_addr_i(a0), .req0_wdata_i(d0),
    .req0_ready_o(rdy0), .req0_done_o(dn0), .req0_err_o(er0),
    .req1_valid_i(v1), .req1_write_i(w1), .req1_addr_i(a1), .req1_wdata_i(d1),
    .req1_ready_o(rdy1), .req1_done_o(dn1), .req1_err_o(er1),
    .rdata_o(rdata), .mem_read_o(mrd), .mem_write_o(mwr), .mem_addr_o(maddr),
    .mem_wdata_o(mwdata), .mem_rdata_i(mrdata), .busy_o(busy)
  );

  dmem_arbiter #(.MEM_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(b_v0), .req0_write_i(1'b0), .req0_addr_i(b_a0), .req0_wdata_i(32'h0),
    .req0_ready_o(b_rdy0), .req0_done_o(b_dn0), .req0_err_o(b_er0),
    .req1_valid_i(1'b0), .req1_write_i(1'b0), .req1_addr_i(32'h0), .req1_wdata_i(32'h0),
    .req1_ready_o(b_rdy1), .req1_done_o(b_dn1), .req1_err_o(b_er1),
    .rdata_o(b_rdata), .mem_read_o(b_mrd), .mem_write_o(b_mwr), .mem_addr_o(b_maddr),
    .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata), .busy_o(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and tracks strobes per transaction.
  int          n_rd = 0;
  int          n_wr = 0;
  int          wr_cyc = -1;
  logic [31:0] wr_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_rd = 0;
      n_wr = 0;
    end else begin
      if (mrd) n_rd++;
      if (mwr) begin
        n_wr++;
        wr_cyc  = cyc;
        wr_addr = maddr;
      end
      check("strobe_excl", 32'(mrd & mwr), 32'd0);
      if (dn0 || dn1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'({dn1, dn0}), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("done_port", 32'({dn1, dn0}), (e.port == 1) ? 32'd2 : 32'd1);
          check("err", 32'({er1, er0}), e.err ? ((e.port == 1) ? 32'd2 : 32'd1) : 32'd0);
          check("done_cyc", 32'(cyc), 32'(e.done_cyc));
          if (e.chk_rd) check("rdata", rdata, e.rd);
          check("n_rd", 32'(n_rd), 32'(e.nrd));
          check("n_wr", 32'(n_wr), 32'(e.nwr));
          if (e.nwr == 1) begin
            check("wr_cyc", 32'(wr_cyc), 32'(e.done_cyc - 1));
            check("wr_addr", wr_addr, e.waddr);
          end
        end
        n_rd = 0;
        n_wr = 0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input bit eerr, input bit chk, input logic [31:0] erd);
    exp_t e;
    int   acc = 0;
    bit   got = 1'b0;
    if (p) begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    else   begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
    for (int k = 0; k < 100 && !got; k++) begin
      #1;
      if ((p ? rdy1 : rdy0) === 1'b1) begin
        got = 1'b1;
        acc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      if (exp_grant_q.size() > 0) check("grant_port", 32'(p), 32'(exp_grant_q.pop_front()));
      acc_log.push_back(acc);
      e.port     = p ? 1 : 0;
      e.err      = eerr;
      e.chk_rd   = chk;
      e.rd       = erd;
      e.done_cyc = acc + (eerr ? 1 : LAT + 1);
      e.nrd      = (eerr || w) ? 0 : LAT;
      e.nwr      = (!eerr && w) ? 1 : 0;
      e.waddr    = {a[31:2], 2'b00};
      sb_q.push_back(e);
    end
    @(negedge clk);
    // Post-accept changes must be ignored by the DUT.
    if (p) begin v1 = 1'b0; w1 = ~w; a1 = 32'hFFFF_FFFC; d1 = ~d; end
    else   begin v0 = 1'b0; w0 = ~w; a0 = 32'hFFFF_FFFC; d0 = ~d; end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (sb_q.size() == 0 && busy == 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bacc[$];
    int bdone[$];
    int brd[$];
    rst_n = 1'b0;
    v0 = 0; w0 = 0; a0 = '0; d0 = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    b_v0 = 0; b_a0 = '0;
    repeat (3) @(negedge clk);

    check("rst_rdata", rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({mrd, mwr}), 32'd0);
    check("rst_addr", maddr, 32'd0);
    check("rst_done", 32'({dn1, dn0}), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);

    // Single load, then single store and read-back.
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    acc = acc_log[acc_log.size() - 1];
    check("busy_c1", 32'(busy), 32'd1);
    while (cyc < acc + 4) @(negedge clk);
    check("busy_c4", 32'(busy), 32'd0);
    drive(1'b1, 1'b1, 32'h24, 32'h1234_5678, 1'b0, 1'b1, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    wait_idle();
    check("mem_24", mem[9], 32'h1234_5678);

    // Contention from reset: both ports continuously valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acc_log.delete();
    exp_grant_q = '{0, 1, 0, 1};
    fork
      begin
        drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      end
      begin
        drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      end
    join
    wait_idle();
    check("cont_n", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4)
      for (int i = 1; i < 4; i++) check("cont_spacing", 32'(acc_log[i] - acc_log[0]), 32'(4 * i));

    // Misaligned store, then a load accepted two cycles later.
    acc_log.delete();
    drive(1'b0, 1'b1, 32'h13, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_idle();
    check("mis_mem", mem[4], 32'hDEAD_BEEF);
    if (acc_log.size() == 2) check("mis_next_acc", 32'(acc_log[1] - acc_log[0]), 32'd2);
    else check("mis_acc_n", 32'(acc_log.size()), 32'd2);

    // Reset in the write cycle of a store.
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h30; d0 = 32'hCAFE_F00D;
    #1;
    check("mid_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);
    check("mid_wr_c2", 32'(mwr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_wr_drop", 32'(mwr), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_mem", mem[12], 32'd0);
    exp_grant_q = '{0, 1};
    fork
      drive(1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
      drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    join
    wait_idle();

    // MEM_LAT=1 instance: continuous loads.
    b_v0 = 1'b1;
    b_a0 = 32'h10;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (b_rdy0) bacc.push_back(cyc);
      if (b_dn0)  bdone.push_back(cyc);
      if (b_mrd)  brd.push_back(cyc);
      @(negedge clk);
    end
    b_v0 = 1'b0;
    check("l1_acc_n", 32'(bacc.size()), 32'd4);
    check("l1_done_n", 32'(bdone.size()), 32'd3);
    check("l1_rd_n", 32'(brd.size()), 32'd3);
    if (bacc.size() == 4 && bdone.size() == 3 && brd.size() == 3) begin
      for (int i = 1; i < 4; i++) check("l1_acc", 32'(bacc[i]), 32'(bacc[0] + 3 * i));
      for (int i = 0; i < 3; i++) begin
        check("l1_rd", 32'(brd[i]), 32'(bacc[i] + 1));
        check("l1_done", 32'(bdone[i]), 32'(bacc[i] + 2));
      end
    end
    repeat (3) @(negedge clk);
    check("l1_rdata", b_rdata, 32'hDEAD_BEEF);
    check("l1_misc", 32'({b_er0, b_er1, b_dn1, b_mwr, b_busy}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
